// File: rtl/router_register_param.sv
// rtl/router_register_param.sv - parametrised router datapath register stage with integrity and length check
module router_register_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 2,
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned CHECK_MODE   = 0,
  localparam int unsigned LEN_WIDTH   = DATA_WIDTH - ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  rst_int_reg,
  input  logic                  detect_addr,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  error,
  output logic                  len_error,
  output logic [LEN_WIDTH-1:0]  payload_cnt
);

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = {LEN_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] check_q, check_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  low_q, low_d;
  logic                  pdone_q, pdone_d;
  logic                  err_q, err_d;
  logic                  lerr_q, lerr_d;
  logic                  addr_ok;
  logic                  payload_beat;
  logic [DATA_WIDTH-1:0] acc_next;

  assign addr_ok      = 32'(data_in[ADDR_WIDTH-1:0]) < NUM_CHANNELS;
  assign payload_beat = ld_state && pkt_valid && !full_state;

  // Integrity accumulator step: XOR parity or additive checksum wrapping at the byte width
  always_comb begin
    acc_next = acc_q ^ data_in;
    if (CHECK_MODE == 1) acc_next = acc_q + data_in;
  end

  // Next-state for the datapath; detect_addr clears are applied last so they override any other state action
  always_comb begin
    header_d   = header_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    acc_d      = acc_q;
    check_d    = check_q;
    cnt_d      = cnt_q;
    low_d      = low_q;
    pdone_d    = pdone_q;
    err_d      = err_q;
    lerr_d     = lerr_q;

    if (detect_addr && pkt_valid && addr_ok) header_d = data_in;

    if (lfd_state)                                data_out_d = header_q;
    else if (ld_state && pkt_valid && !fifo_full) data_out_d = data_in;
    else if (laf_state)                           data_out_d = hold_q;

    if (ld_state && fifo_full) hold_d = data_in;

    if (lfd_state)         acc_d = header_q;
    else if (payload_beat) acc_d = acc_next;

    if (payload_beat && (cnt_q != CNT_MAX)) cnt_d = cnt_q + LEN_WIDTH'(1);

    if (ld_state && !pkt_valid) begin
      check_d = data_in;
      low_d   = 1'b1;
    end
    if (rst_int_reg) low_d = 1'b0;

    if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && low_q && !pdone_q)) pdone_d = 1'b1;

    // Verdicts are re-evaluated every cycle the packet is closed, from registered state only
    if (pdone_q) begin
      err_d  = (acc_q != check_q);
      lerr_d = (cnt_q != header_q[DATA_WIDTH-1:ADDR_WIDTH]);
    end

    if (detect_addr) begin
      pdone_d = 1'b0;
      err_d   = 1'b0;
      lerr_d  = 1'b0;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      header_q   <= '0;
      hold_q     <= '0;
      data_out_q <= '0;
      acc_q      <= '0;
      check_q    <= '0;
      cnt_q      <= '0;
      low_q      <= 1'b0;
      pdone_q    <= 1'b0;
      err_q      <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      header_q   <= header_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      acc_q      <= acc_d;
      check_q    <= check_d;
      cnt_q      <= cnt_d;
      low_q      <= low_d;
      pdone_q    <= pdone_d;
      err_q      <= err_d;
      lerr_q     <= lerr_d;
    end
  end

  assign data_out      = data_out_q;
  assign parity_done   = pdone_q;
  assign low_pkt_valid = low_q;
  assign error         = err_q;
  assign len_error     = lerr_q;
  assign payload_cnt   = cnt_q;

endmodule

// File: tb/tb_router_register_param.sv
// tb/tb_router_register_param.sv - scoreboard bench for router_register_param in XOR and checksum modes
module tb_router_register_param;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_DET  = 5'b10000;
  localparam logic [4:0] S_LFD  = 5'b01000;
  localparam logic [4:0] S_LD   = 5'b00100;
  localparam logic [4:0] S_LAF  = 5'b00010;
  localparam logic [4:0] S_FULL = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0, fifo_full = 1'b0, rst_int_reg = 1'b0;
  logic       detect_addr = 1'b0, lfd_state = 1'b0, ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout_x, dout_a;
  logic       pd_x, pd_a, low_x, low_a, err_x, err_a, lerr_x, lerr_a;
  logic [5:0] cnt_x, cnt_a;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_x[$];
  logic [7:0] got_a[$];

  always #5 clk = ~clk;

  router_register_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CHANNELS(3), .CHECK_MODE(0)) dut_x (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fifo_full(fifo_full), .rst_int_reg(rst_int_reg),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .data_in(data_in), .data_out(dout_x), .parity_done(pd_x),
    .low_pkt_valid(low_x), .error(err_x), .len_error(lerr_x), .payload_cnt(cnt_x));

  router_register_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CHANNELS(3), .CHECK_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fifo_full(fifo_full), .rst_int_reg(rst_int_reg),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .data_in(data_in), .data_out(dout_a), .parity_done(pd_a),
    .low_pkt_valid(low_a), .error(err_a), .len_error(lerr_a), .payload_cnt(cnt_a));

  function automatic logic [7:0] xsum(input logic [7:0] h, input int n);
    logic [7:0] a;
    a = h;
    for (int i = 1; i <= n; i++) a = a ^ 8'(i);
    return a;
  endfunction

  function automatic logic [7:0] asum(input logic [7:0] h, input int n);
    logic [7:0] a;
    a = h;
    for (int i = 1; i <= n; i++) a = a + 8'(i);
    return a;
  endfunction

  // One clock of stimulus; data_out is captured when the sampled state should have produced a byte
  task automatic cyc(input logic [4:0] st, input logic pv, input logic ff, input logic rir, input logic [7:0] d);
    {detect_addr, lfd_state, ld_state, laf_state, full_state} = st;
    pkt_valid = pv; fifo_full = ff; rst_int_reg = rir; data_in = d;
    @(posedge clk); #1;
    if (!rst && (st[3] || (st[2] && pv && !ff) || st[1])) begin
      got_x.push_back(dout_x);
      got_a.push_back(dout_a);
    end
  endtask

  task automatic send_hdr(input logic [7:0] hdr);
    cyc(S_DET, 1'b1, 1'b0, 1'b0, hdr);
    exp_q.push_back(hdr);
    cyc(S_LFD, 1'b1, 1'b0, 1'b0, hdr);
  endtask

  task automatic send_body(input int n, input logic [7:0] chk, input logic rir);
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back(8'(i));
      cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'(i));
    end
    cyc(S_LD, 1'b0, 1'b0, rir, chk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({dout_x, pd_x, low_x, err_x, lerr_x, cnt_x} !== 19'd0) begin
      failures++; $display("FAIL reset_x got %h exp 0", {dout_x, pd_x, low_x, err_x, lerr_x, cnt_x});
    end
    checks++;
    if ({dout_a, pd_a, low_a, err_a, lerr_a, cnt_a} !== 19'd0) begin
      failures++; $display("FAIL reset_a got %h exp 0", {dout_a, pd_a, low_a, err_a, lerr_a, cnt_a});
    end
    rst = 1'b0;
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_xor_good();
    logic [7:0] e, gx, ga;
    send_hdr(8'h16);
    send_body(5, 8'h17, 1'b0);
    checks++;
    if ({pd_x, pd_a, low_x} !== 3'b111) begin
      failures++; $display("FAIL xor_good_pdone got %b exp 111", {pd_x, pd_a, low_x});
    end
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_x, lerr_x, cnt_x} !== {1'b0, 1'b0, 6'd5}) begin
      failures++; $display("FAIL xor_good_verdict got err=%b lerr=%b cnt=%0d exp 0 0 5", err_x, lerr_x, cnt_x);
    end
    checks++;
    if (err_a !== 1'b1) begin
      failures++; $display("FAIL add_chk17_error got %b exp 1", err_a);
    end
    cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (low_x !== 1'b0) begin
      failures++; $display("FAIL rst_int_reg_clear got %b exp 0", low_x);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_x.size() == 0) begin failures++; $display("FAIL xor_good_dout missing exp %h", e); end
      else begin
        gx = got_x.pop_front(); ga = got_a.pop_front();
        if (gx !== e || ga !== e) begin failures++; $display("FAIL xor_good_dout got %h/%h exp %h", gx, ga, e); end
      end
    end
    got_x.delete(); got_a.delete();
  endtask

  task automatic test_bad_check();
    logic [7:0] e, gx, ga;
    send_hdr(8'h16);
    send_body(5, 8'h55, 1'b0);
    checks++;
    if ({pd_x, err_x} !== 2'b10) begin
      failures++; $display("FAIL bad_check_at_pdone got pd=%b err=%b exp 1 0", pd_x, err_x);
    end
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_x, err_a, lerr_x} !== 3'b110) begin
      failures++; $display("FAIL bad_check_error got %b exp 110", {err_x, err_a, lerr_x});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_x.size() == 0) begin failures++; $display("FAIL bad_check_dout missing exp %h", e); end
      else begin
        gx = got_x.pop_front(); ga = got_a.pop_front();
        if (gx !== e || ga !== e) begin failures++; $display("FAIL bad_check_dout got %h/%h exp %h", gx, ga, e); end
      end
    end
    got_x.delete(); got_a.delete();
  endtask

  task automatic test_add_good();
    send_hdr(8'h16);
    checks++;
    if ({pd_x, err_x, lerr_x, cnt_x} !== 9'd0) begin
      failures++; $display("FAIL detect_clear got %b exp 0", {pd_x, err_x, lerr_x, cnt_x});
    end
    send_body(5, asum(8'h16, 5), 1'b0);
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_a, err_x, lerr_a, cnt_a} !== {1'b0, 1'b1, 1'b0, 6'd5}) begin
      failures++; $display("FAIL add_good got err_a=%b err_x=%b lerr_a=%b cnt=%0d exp 0 1 0 5", err_a, err_x, lerr_a, cnt_a);
    end
    exp_q.delete(); got_x.delete(); got_a.delete();
  endtask

  task automatic test_short();
    send_hdr(8'h16);
    send_body(4, xsum(8'h16, 4), 1'b1);
    checks++;
    if ({pd_x, low_x} !== 2'b10) begin
      failures++; $display("FAIL short_rir_wins got pd=%b low=%b exp 1 0", pd_x, low_x);
    end
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_x, lerr_x, cnt_x} !== {1'b0, 1'b1, 6'd4}) begin
      failures++; $display("FAIL short_len got err=%b lerr=%b cnt=%0d exp 0 1 4", err_x, lerr_x, cnt_x);
    end
    exp_q.delete(); got_x.delete(); got_a.delete();
  endtask

  task automatic test_fifo_full();
    logic [7:0] e, gx, ga;
    send_hdr(8'h16);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'(i));
    end
    cyc(S_LD, 1'b1, 1'b1, 1'b0, 8'hAA);
    cyc(S_FULL, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout_x !== 8'h04) begin
      failures++; $display("FAIL full_hold got %h exp 04", dout_x);
    end
    exp_q.push_back(8'hAA);
    cyc(S_LAF, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(S_LD, 1'b0, 1'b1, 1'b0, 8'hB8);
    checks++;
    if ({low_x, pd_x, dout_x} !== {1'b1, 1'b0, 8'hAA}) begin
      failures++; $display("FAIL full_chk got low=%b pd=%b dout=%h exp 1 0 aa", low_x, pd_x, dout_x);
    end
    cyc(S_FULL, 1'b0, 1'b1, 1'b0, 8'h00);
    exp_q.push_back(8'hB8);
    cyc(S_LAF, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (pd_x !== 1'b1) begin
      failures++; $display("FAIL laf_pdone got %b exp 1", pd_x);
    end
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_x, lerr_x, cnt_x, err_a} !== {1'b0, 1'b0, 6'd5, 1'b1}) begin
      failures++; $display("FAIL full_verdict got err=%b lerr=%b cnt=%0d err_a=%b exp 0 0 5 1", err_x, lerr_x, cnt_x, err_a);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_x.size() == 0) begin failures++; $display("FAIL full_dout missing exp %h", e); end
      else begin
        gx = got_x.pop_front(); ga = got_a.pop_front();
        if (gx !== e || ga !== e) begin failures++; $display("FAIL full_dout got %h/%h exp %h", gx, ga, e); end
      end
    end
    got_x.delete(); got_a.delete();
    cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_saturate();
    send_hdr(8'h29);
    send_body(70, xsum(8'h29, 70), 1'b0);
    cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err_x, lerr_x, cnt_x} !== {1'b0, 1'b1, 6'd63}) begin
      failures++; $display("FAIL saturate got err=%b lerr=%b cnt=%0d exp 0 1 63", err_x, lerr_x, cnt_x);
    end
    exp_q.delete(); got_x.delete(); got_a.delete();
  endtask

  task automatic test_bad_addr_and_reset();
    logic [7:0] e, gx, ga;
    send_hdr(8'h16);
    exp_q.delete(); got_x.delete(); got_a.delete();
    cyc(S_DET, 1'b1, 1'b0, 1'b0, 8'h17);
    exp_q.push_back(8'h16);
    cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h17);
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(8'(i));
      cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'(i));
    end
    rst = 1'b1;
    cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'h03);
    rst = 1'b0;
    checks++;
    if ({dout_x, pd_x, low_x, err_x, lerr_x, cnt_x} !== 19'd0) begin
      failures++; $display("FAIL mid_reset got %h exp 0", {dout_x, pd_x, low_x, err_x, lerr_x, cnt_x});
    end
    exp_q.push_back(8'h00);
    cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_x.size() == 0) begin failures++; $display("FAIL bad_addr_dout missing exp %h", e); end
      else begin
        gx = got_x.pop_front(); ga = got_a.pop_front();
        if (gx !== e || ga !== e) begin failures++; $display("FAIL bad_addr_dout got %h/%h exp %h", gx, ga, e); end
      end
    end
    got_x.delete(); got_a.delete();
  endtask

  initial begin
    test_reset();
    test_xor_good();
    test_bad_check();
    test_add_good();
    test_short();
    test_fifo_full();
    test_saturate();
    test_bad_addr_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
